// File: rtl/mul_share_arb_if.sv
// Bundle of requester-side and multiplier-side signals for the shared-multiplier arbiter.
// The arbiter takes the slave view; the surrounding datapath/multiplier take the master view.
interface mul_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                en;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   a_in;
  logic [NREQ*W-1:0]   b_in;
  logic [NREQ-1:0]     gnt;
  logic [W-1:0]        mul_a;
  logic [W-1:0]        mul_b;
  logic [2*W-1:0]      mul_p;
  logic                rsp_valid;
  logic [IW-1:0]       rsp_id;
  logic [2*W-1:0]      rsp_p;
  logic                busy;

  modport slave (
    input  en, req, a_in, b_in, mul_p,
    output gnt, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, busy
  );

  modport master (
    output en, req, a_in, b_in, mul_p,
    input  gnt, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ requesters,
// tagging each issued operation so its product returns with the issuer's id.
module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  mul_share_arb_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    mulA_q, mulA_d;
  logic [W-1:0]    mulB_q, mulB_d;
  logic [LAT:0]    tagValid_q, tagValid_d;
  logic [IW-1:0]   tagId_q [LAT+1];
  logic            rspValid_q;
  logic [IW-1:0]   rspId_q;
  logic [2*W-1:0]  rspP_q;

  logic            gntAny;
  logic [IW-1:0]   gntIdx;
  logic [NREQ-1:0] gntVec;
  int              idx;

  // Search upward from ptr with wrap; the first hit wins.
  always_comb begin
    gntAny = 1'b0;
    gntIdx = '0;
    gntVec = '0;
    idx    = 0;
    if (!rst && bus.en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gntAny && bus.req[idx]) begin
          gntAny = 1'b1;
          gntIdx = IW'(idx);
        end
      end
    end
    if (gntAny) gntVec[gntIdx] = 1'b1;
  end

  always_comb begin
    ptr_d  = ptr_q;
    mulA_d = mulA_q;
    mulB_d = mulB_q;
    if (gntAny) begin
      ptr_d  = (int'(gntIdx) == NREQ - 1) ? '0 : gntIdx + IW'(1);
      mulA_d = bus.a_in[int'(gntIdx)*W +: W];
      mulB_d = bus.b_in[int'(gntIdx)*W +: W];
    end
    tagValid_d = {tagValid_q[LAT-1:0], gntAny};
  end

  // The tag is held one stage beyond the multiplier latency so it lines up
  // with the edge at which the product is registered into rsp_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      mulA_q     <= '0;
      mulB_q     <= '0;
      tagValid_q <= '0;
      for (int s = 0; s <= LAT; s++) tagId_q[s] <= '0;
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
      rspP_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      mulA_q     <= mulA_d;
      mulB_q     <= mulB_d;
      tagValid_q <= tagValid_d;
      tagId_q[0] <= gntIdx;
      for (int s = 1; s <= LAT; s++) tagId_q[s] <= tagId_q[s-1];
      rspValid_q <= tagValid_q[LAT];
      if (tagValid_q[LAT]) begin
        rspId_q <= tagId_q[LAT];
        rspP_q  <= bus.mul_p;
      end
    end
  end

  assign bus.gnt       = gntVec;
  assign bus.mul_a     = mulA_q;
  assign bus.mul_b     = mulB_q;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_id    = rspId_q;
  assign bus.rsp_p     = rspP_q;
  assign bus.busy      = |tagValid_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed scenarios with literal expectations, then
// constrained-random requesters, all checked every cycle against a queue-based model.
module tb_mul_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_share_arb_if #(.NREQ(NREQ), .W(W)) bus();

  mul_share_arb #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for the shared multiplier: product appears LAT edges after operands.
  logic [2*W-1:0] mulPipe [LAT];
  always @(posedge clk) begin
    mulPipe[0] <= bus.mul_a * bus.mul_b;
    for (int s = 1; s < LAT; s++) mulPipe[s] <= mulPipe[s-1];
  end
  assign bus.mul_p = mulPipe[LAT-1];

  int compared   = 0;
  int mismatched = 0;
  bit checkOn    = 1'b0;

  typedef struct {
    int             id;
    logic [15:0]    p;
    int             due;
  } opT;

  opT          pend[$];
  int          ptrM       = 0;
  int          cycleM     = 0;
  int          lastGrantM = -1;
  logic        expValid   = 1'b0;
  logic [1:0]  expId      = '0;
  logic [15:0] expP       = '0;
  logic [7:0]  expA       = '0;
  logic [7:0]  expB       = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic e,
                               input logic [31:0] aV, input logic [31:0] bV);
    @(posedge clk);
    #1;
    bus.req  = r;
    bus.en   = e;
    bus.a_in = aV;
    bus.b_in = bV;
  endtask

  function automatic int modelGrant();
    if (rst || !bus.en) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req[(ptrM + k) % NREQ]) return (ptrM + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [7:0] pickOp();
    int r;
    r = $urandom_range(7);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'hFF;
    return 8'($urandom_range(255));
  endfunction

  // Reference: each grant becomes an entry with its product and the edge it must come back on.
  always @(posedge clk or posedge rst) begin
    int g;
    logic [7:0] a;
    logic [7:0] b;
    if (rst) begin
      pend.delete();
      ptrM       = 0;
      lastGrantM = -1;
      expValid   = 1'b0;
      expId      = '0;
      expP       = '0;
      expA       = '0;
      expB       = '0;
    end else begin
      cycleM++;
      g = modelGrant();
      expValid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cycleM) begin
        expValid = 1'b1;
        expId    = 2'(pend[0].id);
        expP     = pend[0].p;
        void'(pend.pop_front());
      end
      if (g >= 0) begin
        a = bus.a_in[g*W +: W];
        b = bus.b_in[g*W +: W];
        pend.push_back('{g, 16'(a) * 16'(b), cycleM + LAT + 1});
        expA = a;
        expB = b;
        ptrM = (g + 1) % NREQ;
      end
      lastGrantM = g;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [3:0] eg;
    if (checkOn) begin
      g  = modelGrant();
      eg = (g >= 0) ? 4'(1 << g) : 4'b0000;
      checkOutput("gnt",       32'(bus.gnt),       32'(eg));
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(expValid));
      checkOutput("rsp_id",    32'(bus.rsp_id),    32'(expId));
      checkOutput("rsp_p",     32'(bus.rsp_p),     32'(expP));
      checkOutput("mul_a",     32'(bus.mul_a),     32'(expA));
      checkOutput("mul_b",     32'(bus.mul_b),     32'(expB));
      checkOutput("busy",      32'(bus.busy),      32'(pend.size() != 0));
    end
  end

  initial begin
    logic [3:0]  gArr [8];
    logic        vArr [8];
    logic [1:0]  idArr [8];
    logic [15:0] pArr [8];
    logic [3:0]  seqG [8];
    logic [15:0] prod [4];
    logic [3:0]  pending;
    logic [7:0]  opA [NREQ];
    logic [7:0]  opB [NREQ];

    bus.en   = 1'b1;
    bus.req  = 4'hF;
    bus.a_in = '0;
    bus.b_in = '0;
    rst      = 1'b1;
    checkOn  = 1'b1;
    seqG = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    prod = '{16'd10, 16'd40, 16'd90, 16'd160};

    // Reset holds everything quiet even with all requests high.
    @(negedge clk);
    checkOutput("rst_gnt",   32'(bus.gnt),       32'h0);
    checkOutput("rst_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("rst_rsp_p", 32'(bus.rsp_p),     32'h0);
    checkOutput("rst_busy",  32'(bus.busy),      32'h0);
    checkOutput("rst_mul_a", 32'(bus.mul_a),     32'h0);

    // All four requesting: rotation 0..3 and in-order responses three negedges later.
    bus.a_in = 32'h04030201;
    bus.b_in = 32'h281E140A;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      gArr[k]  = bus.gnt;
      vArr[k]  = bus.rsp_valid;
      idArr[k] = bus.rsp_id;
      pArr[k]  = bus.rsp_p;
    end
    for (int k = 0; k < 8; k++) begin
      checkOutput("rr_gnt", 32'(gArr[k]), 32'(seqG[k]));
      if (k < 3) begin
        checkOutput("rr_valid_early", 32'(vArr[k]), 32'h0);
      end else begin
        checkOutput("rr_valid", 32'(vArr[k]),  32'h1);
        checkOutput("rr_id",    32'(idArr[k]), 32'((k - 3) % 4));
        checkOutput("rr_p",     32'(pArr[k]),  32'(prod[(k - 3) % 4]));
      end
    end
    applyStimulus(4'h0, 1'b1, '0, '0);
    repeat (4) @(negedge clk);

    // Single op 25*5.
    applyStimulus(4'b0001, 1'b1, 32'd25, 32'd5);
    @(negedge clk);
    checkOutput("single_gnt", 32'(bus.gnt), 32'h1);
    applyStimulus(4'h0, 1'b1, 32'd25, 32'd5);
    @(negedge clk);
    checkOutput("single_gnt_once", 32'(bus.gnt), 32'h0);
    @(negedge clk);
    checkOutput("single_valid_early", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    checkOutput("single_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("single_id",    32'(bus.rsp_id),    32'h0);
    checkOutput("single_p",     32'(bus.rsp_p),     32'd125);
    @(negedge clk);
    checkOutput("single_pulse", 32'(bus.rsp_valid), 32'h0);

    // Requesters 0 and 3 from ptr=0 alternate across the wrap.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(4'b1001, 1'b1, 32'h09000007, 32'h0B000003);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("wrap_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'h1 : 32'h8);
    end
    applyStimulus(4'h0, 1'b1, '0, '0);
    repeat (4) @(negedge clk);

    // Operand extremes from requester 1.
    applyStimulus(4'b0010, 1'b1, 32'h0000FF00, 32'h0000FF00);
    @(negedge clk);
    checkOutput("ext_gnt0", 32'(bus.gnt), 32'h2);
    applyStimulus(4'b0010, 1'b1, 32'h00000000, 32'h0000A500);
    @(negedge clk);
    checkOutput("ext_gnt1", 32'(bus.gnt), 32'h2);
    applyStimulus(4'h0, 1'b1, '0, '0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ext_id_ff", 32'(bus.rsp_id), 32'h1);
    checkOutput("ext_p_ff",  32'(bus.rsp_p),  32'hFE01);
    @(negedge clk);
    checkOutput("ext_valid_zero", 32'(bus.rsp_valid), 32'h1);
    checkOutput("ext_p_zero",     32'(bus.rsp_p),     32'h0);

    // Reset right after an issue discards that op.
    applyStimulus(4'b0001, 1'b1, 32'd7, 32'd9);
    @(negedge clk);
    checkOutput("abort_gnt", 32'(bus.gnt), 32'h1);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    bus.req = 4'h0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("abort_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end

    // Dropping en stops grants while in-flight ops drain.
    applyStimulus(4'hF, 1'b1, 32'h44332211, 32'h88776655);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(4'hF, 1'b0, 32'h44332211, 32'h88776655);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("en0_gnt", 32'(bus.gnt), 32'h0);
      if (k == 0) checkOutput("en0_busy_inflight", 32'(bus.busy), 32'h1);
      if (k == 4) checkOutput("en0_busy_drained",  32'(bus.busy), 32'h0);
    end
    applyStimulus(4'h0, 1'b1, '0, '0);
    repeat (3) @(negedge clk);

    // Random requesters honouring the hold-until-granted contract.
    pending = '0;
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (lastGrantM >= 0) pending[lastGrantM] = 1'b0;
      if (rst) rst = 1'b0;
      else if ($urandom_range(199) == 0) rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && $urandom_range(1) == 1) begin
          pending[i] = 1'b1;
          opA[i]     = pickOp();
          opB[i]     = pickOp();
        end
        bus.a_in[i*W +: W] = opA[i];
        bus.b_in[i*W +: W] = opB[i];
      end
      bus.req = pending;
      bus.en  = ($urandom_range(7) != 0);
    end

    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.req = '0;
    bus.en  = 1'b1;
    repeat (5) @(negedge clk);
    checkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
